// File: rtl/sprite_motion_array_if.sv
// Bus bundle for sprite_motion_array: frame request, object writes and
// the packed position / status outputs.
interface sprite_motion_array_if #(
   parameter int NUM_OBJ = 4,
   parameter int POS_W   = 10,
   parameter int VEL_W   = 8
);
   localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   logic                       frame_tick;
   logic                       wr_en;
   logic                       wr_pos;
   logic [IW-1:0]              wr_idx;
   logic [POS_W-1:0]           wr_x;
   logic [POS_W-1:0]           wr_y;
   logic signed [VEL_W-1:0]    wr_vx;
   logic signed [VEL_W-1:0]    wr_vy;
   logic [NUM_OBJ*POS_W-1:0]   pos_x;
   logic [NUM_OBJ*POS_W-1:0]   pos_y;
   logic [POS_W-1:0]           obj_size;
   logic                       busy;
   logic                       done;
   logic [NUM_OBJ-1:0]         edge_hit;

   modport master (
      output frame_tick, wr_en, wr_pos, wr_idx, wr_x, wr_y, wr_vx, wr_vy,
      input  pos_x, pos_y, obj_size, busy, done, edge_hit
   );

   modport slave (
      input  frame_tick, wr_en, wr_pos, wr_idx, wr_x, wr_y, wr_vx, wr_vy,
      output pos_x, pos_y, obj_size, busy, done, edge_hit
   );
endinterface

// File: rtl/sprite_motion_array.sv
// sprite_motion_array: moves NUM_OBJ objects one frame per frame_tick,
// one object per clock, with bounce / wrap / clamp screen-edge handling.
// Optional sticky per-object boundary flags: define SPRITE_EDGE_EVENT_EN.
//
// state  | meaning
// IDLE   | waiting for frame_tick
// RUN    | updating object idx_q this edge, 0 .. NUM_OBJ-1
// DONE   | one-cycle completion pulse
module sprite_motion_array #(
   parameter int NUM_OBJ   = 4,
   parameter int POS_W     = 10,
   parameter int VEL_W     = 8,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 639,
   parameter int Y_MIN     = 0,
   parameter int Y_MAX     = 479,
   parameter int X_INIT    = 320,
   parameter int Y_INIT    = 240,
   parameter int SIZE      = 4,
   parameter int EDGE_MODE = 0
) (
   input  logic                   frame_clk_i,
   input  logic                   reset_i,
   sprite_motion_array_if.slave   bus_if
);
   localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam logic signed [VEL_W-1:0] V_MIN = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic signed [VEL_W-1:0] V_MAX = ~V_MIN;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [POS_W-1:0]        px_q [NUM_OBJ];
   logic [POS_W-1:0]        px_d [NUM_OBJ];
   logic [POS_W-1:0]        py_q [NUM_OBJ];
   logic [POS_W-1:0]        py_d [NUM_OBJ];
   logic signed [VEL_W-1:0] vx_q [NUM_OBJ];
   logic signed [VEL_W-1:0] vx_d [NUM_OBJ];
   logic signed [VEL_W-1:0] vy_q [NUM_OBJ];
   logic signed [VEL_W-1:0] vy_d [NUM_OBJ];
   logic [NUM_OBJ*POS_W-1:0] px_flat, py_flat;

   // p + v at POS_W+2 bits signed, widened to int for the limit compares
   function automatic int axis_sum(input logic [POS_W-1:0] p,
                                   input logic signed [VEL_W-1:0] v);
      logic signed [POS_W+1:0] n;
      n = $signed({2'b00, p}) + (POS_W+2)'(v);
      return int'(n);
   endfunction

   function automatic logic signed [VEL_W-1:0] abs_sat(input logic signed [VEL_W-1:0] v);
      if (v == V_MIN) return V_MAX;
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [POS_W-1:0] axis_pos(input logic [POS_W-1:0] p,
                                                 input logic signed [VEL_W-1:0] v,
                                                 input int lo, input int hi);
      int n;
      n = axis_sum(p, v);
      if (EDGE_MODE == 1) begin
         if (n > hi)      return POS_W'(n - (hi - lo + 1));
         else if (n < lo) return POS_W'(n + (hi - lo + 1));
         return POS_W'(n);
      end
      if (n + SIZE > hi)      return POS_W'(hi - SIZE);
      else if (n - SIZE < lo) return POS_W'(lo + SIZE);
      return POS_W'(n);
   endfunction

   function automatic logic signed [VEL_W-1:0] axis_vel(input logic [POS_W-1:0] p,
                                                        input logic signed [VEL_W-1:0] v,
                                                        input int lo, input int hi);
      int n;
      n = axis_sum(p, v);
      if (EDGE_MODE == 1) return v;
      if (n + SIZE > hi)      return (EDGE_MODE == 2) ? '0 : -abs_sat(v);
      else if (n - SIZE < lo) return (EDGE_MODE == 2) ? '0 : abs_sat(v);
      return v;
   endfunction

   // state register
   always_ff @(posedge frame_clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // next-state: ticks outside IDLE are ignored
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: if (bus_if.frame_tick) begin
            state_d = S_RUN;
            idx_d   = '0;
         end
         S_RUN: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(NUM_OBJ-1)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus_if.busy = (state_q == S_RUN);
      bus_if.done = (state_q == S_DONE);
   end

   // object update then host write; the write lands last so it wins
   always_comb begin
      px_d = px_q;
      py_d = py_q;
      vx_d = vx_q;
      vy_d = vy_q;
      if (state_q == S_RUN) begin
         px_d[idx_q] = axis_pos(px_q[idx_q], vx_q[idx_q], X_MIN, X_MAX);
         py_d[idx_q] = axis_pos(py_q[idx_q], vy_q[idx_q], Y_MIN, Y_MAX);
         vx_d[idx_q] = axis_vel(px_q[idx_q], vx_q[idx_q], X_MIN, X_MAX);
         vy_d[idx_q] = axis_vel(py_q[idx_q], vy_q[idx_q], Y_MIN, Y_MAX);
      end
      if (bus_if.wr_en) begin
         if (bus_if.wr_pos) begin
            px_d[bus_if.wr_idx] = bus_if.wr_x;
            py_d[bus_if.wr_idx] = bus_if.wr_y;
         end else begin
            vx_d[bus_if.wr_idx] = bus_if.wr_vx;
            vy_d[bus_if.wr_idx] = bus_if.wr_vy;
         end
      end
   end

   // object state registers
   always_ff @(posedge frame_clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < NUM_OBJ; k++) begin
            px_q[k] <= POS_W'(X_INIT);
            py_q[k] <= POS_W'(Y_INIT);
            vx_q[k] <= '0;
            vy_q[k] <= '0;
         end
      end else begin
         px_q <= px_d;
         py_q <= py_d;
         vx_q <= vx_d;
         vy_q <= vy_d;
      end
   end

   // pack positions, object k at [k*POS_W +: POS_W]
   always_comb begin
      px_flat = '0;
      py_flat = '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
         px_flat[k*POS_W +: POS_W] = px_q[k];
         py_flat[k*POS_W +: POS_W] = py_q[k];
      end
   end

   assign bus_if.pos_x    = px_flat;
   assign bus_if.pos_y    = py_flat;
   assign bus_if.obj_size = POS_W'(SIZE);

`ifdef SPRITE_EDGE_EVENT_EN
   logic [NUM_OBJ-1:0] hit_q, hit_d;

   function automatic logic axis_hit(input logic [POS_W-1:0] p,
                                     input logic signed [VEL_W-1:0] v,
                                     input int lo, input int hi);
      int n;
      n = axis_sum(p, v);
      if (EDGE_MODE == 1) return (n > hi) || (n < lo);
      return (n + SIZE > hi) || (n - SIZE < lo);
   endfunction

   // sticky flags, cleared when a frame is accepted
   always_comb begin
      hit_d = hit_q;
      if (state_q == S_IDLE && bus_if.frame_tick) hit_d = '0;
      if (state_q == S_RUN &&
          (axis_hit(px_q[idx_q], vx_q[idx_q], X_MIN, X_MAX) ||
           axis_hit(py_q[idx_q], vy_q[idx_q], Y_MIN, Y_MAX)))
         hit_d[idx_q] = 1'b1;
   end

   // flag register
   always_ff @(posedge frame_clk_i) begin
      if (reset_i) hit_q <= '0;
      else         hit_q <= hit_d;
   end

   assign bus_if.edge_hit = hit_q;
`else
   assign bus_if.edge_hit = '0;
`endif
endmodule

// File: tb/tb_sprite_motion_array.sv
// Bench for sprite_motion_array: three instances (bounce, wrap, clamp)
// share one stimulus; per-instance expected frames are queued and popped
// on each done pulse.
module tb_sprite_motion_array;
   localparam bit EV =
`ifdef SPRITE_EDGE_EVENT_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      logic [39:0] px;
      logic [39:0] py;
      logic [3:0]  eh;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_tick = 1'b0, wr_en = 1'b0, wr_pos = 1'b0;
   logic [1:0] wr_idx = '0;
   logic [9:0] wr_x = '0, wr_y = '0;
   logic signed [7:0] wr_vx = '0, wr_vy = '0;

   logic [39:0] px_w [3];
   logic [39:0] py_w [3];
   logic [9:0]  sz_w [3];
   logic        busy_w [3];
   logic        done_w [3];
   logic [3:0]  eh_w [3];

   exp_t qa[$], qb[$], qc[$];
   int done_cnt [3] = '{0, 0, 0};
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic mon(input int g, input logic [39:0] px, input logic [39:0] py, input logic [3:0] eh);
      exp_t e;
      bit ok;
      ok = 1'b0;
      done_cnt[g]++;
      case (g)
         0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
         1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
         default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) begin
         n_chk++;
         $display("FAIL m%0d_unexpected_done: got a done pulse, expected none", g);
      end else begin
         check($sformatf("m%0d_pos_x", g), px, e.px);
         check($sformatf("m%0d_pos_y", g), py, e.py);
         check($sformatf("m%0d_edge_hit", g), eh, e.eh);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : inst
      sprite_motion_array_if #(.NUM_OBJ(4), .POS_W(10), .VEL_W(8)) ifc ();
      assign ifc.frame_tick = frame_tick;
      assign ifc.wr_en      = wr_en;
      assign ifc.wr_pos     = wr_pos;
      assign ifc.wr_idx     = wr_idx;
      assign ifc.wr_x       = wr_x;
      assign ifc.wr_y       = wr_y;
      assign ifc.wr_vx      = wr_vx;
      assign ifc.wr_vy      = wr_vy;
      assign px_w[g]   = ifc.pos_x;
      assign py_w[g]   = ifc.pos_y;
      assign sz_w[g]   = ifc.obj_size;
      assign busy_w[g] = ifc.busy;
      assign done_w[g] = ifc.done;
      assign eh_w[g]   = ifc.edge_hit;

      sprite_motion_array #(.EDGE_MODE(g)) dut (
         .frame_clk_i (clk),
         .reset_i     (rst),
         .bus_if      (ifc)
      );

      always @(negedge clk) if (ifc.done) mon(g, ifc.pos_x, ifc.pos_y, ifc.edge_hit);
   end

   function automatic logic [39:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
   endfunction

   function automatic exp_t mk(input logic [39:0] px, input logic [39:0] py, input logic [3:0] eh);
      exp_t e;
      e.px = px;
      e.py = py;
      e.eh = eh & {4{EV}};
      return e;
   endfunction

   task automatic push3(input exp_t a, input exp_t b, input exp_t c);
      qa.push_back(a);
      qb.push_back(b);
      qc.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit pos, input int idx, input int a, input int b);
      wr_en  = 1'b1;
      wr_pos = pos;
      wr_idx = 2'(idx);
      if (pos) begin wr_x = 10'(a); wr_y = 10'(b); end
      else     begin wr_vx = 8'(a); wr_vy = 8'(b); end
      step();
      wr_en = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("%s_pos_x%0d", tag, g), px_w[g], pk(320, 320, 320, 320));
         check($sformatf("%s_pos_y%0d", tag, g), py_w[g], pk(240, 240, 240, 240));
         check($sformatf("%s_busy_done%0d", tag, g), {busy_w[g], done_w[g]}, 2'b00);
         check($sformatf("%s_edge_hit%0d", tag, g), eh_w[g], 4'h0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // one full pass; noisy adds ticks during RUN and DONE that must be ignored
   task automatic run_pass(input bit noisy, input bit chk_timing);
      frame_tick = 1'b1;
      step();                       // e0 accepted
      frame_tick = noisy;
      if (chk_timing) check("e0_busy_done", {busy_w[0], done_w[0]}, 2'b10);
      step();                       // e1
      frame_tick = 1'b0;
      step();                       // e2
      step();                       // e3
      if (chk_timing) check("e3_busy_done", {busy_w[0], done_w[0]}, 2'b10);
      frame_tick = noisy;
      step();                       // e4, now DONE
      if (chk_timing) check("e4_busy_done", {busy_w[0], done_w[0]}, 2'b01);
      step();                       // e5, back to IDLE
      frame_tick = 1'b0;
      if (chk_timing) check("e5_busy_done", {busy_w[0], done_w[0]}, 2'b00);
      step();
   endtask

   initial begin
      int d;
      step();
      step();
      rst = 1'b0;
      check_reset("rst0");
      check("obj_size", sz_w[0], 10'd4);

      // obj1 moves freely, everyone else stays home
      wr(0, 1, 5, -3);
      push3(mk(pk(320, 325, 320, 320), pk(240, 237, 240, 240), 4'h0),
            mk(pk(320, 325, 320, 320), pk(240, 237, 240, 240), 4'h0),
            mk(pk(320, 325, 320, 320), pk(240, 237, 240, 240), 4'h0));
      run_pass(1'b0, 1'b1);

      // right edge: bounce back, wrap only on the second frame, clamp sticks
      do_reset();
      check_reset("rst1");
      wr(1, 0, 630, 240);
      wr(0, 0, 8, 0);
      push3(mk(pk(635, 320, 320, 320), pk(240, 240, 240, 240), 4'h1),
            mk(pk(638, 320, 320, 320), pk(240, 240, 240, 240), 4'h0),
            mk(pk(635, 320, 320, 320), pk(240, 240, 240, 240), 4'h1));
      run_pass(1'b0, 1'b0);
      push3(mk(pk(627, 320, 320, 320), pk(240, 240, 240, 240), 4'h0),
            mk(pk(6,   320, 320, 320), pk(240, 240, 240, 240), 4'h1),
            mk(pk(635, 320, 320, 320), pk(240, 240, 240, 240), 4'h0));
      run_pass(1'b0, 1'b0);

      // obj2 past the right edge, obj3 past the top edge
      do_reset();
      wr(1, 2, 638, 240);
      wr(0, 2, 5, 0);
      wr(1, 3, 320, 2);
      wr(0, 3, 0, -6);
      push3(mk(pk(320, 320, 635, 320), pk(240, 240, 240, 4),   4'hC),
            mk(pk(320, 320, 3,   320), pk(240, 240, 240, 476), 4'hC),
            mk(pk(320, 320, 635, 320), pk(240, 240, 240, 4),   4'hC));
      run_pass(1'b0, 1'b0);
      push3(mk(pk(320, 320, 630, 320), pk(240, 240, 240, 10),  4'h0),
            mk(pk(320, 320, 8,   320), pk(240, 240, 240, 470), 4'h0),
            mk(pk(320, 320, 635, 320), pk(240, 240, 240, 4),   4'h0));
      d = done_cnt[2];
      run_pass(1'b1, 1'b0);
      repeat (6) step();
      check("noisy_done_count", done_cnt[2] - d, 1);
      check("noisy_idle_busy", {busy_w[0], busy_w[1], busy_w[2]}, 3'b000);
      // obj2 past the left edge
      wr(1, 2, 1, 240);
      wr(0, 2, -4, 0);
      push3(mk(pk(320, 320, 4,   320), pk(240, 240, 240, 16),  4'h4),
            mk(pk(320, 320, 637, 320), pk(240, 240, 240, 464), 4'h4),
            mk(pk(320, 320, 4,   320), pk(240, 240, 240, 4),   4'h4));
      run_pass(1'b0, 1'b0);

      // reset at e2 of a pass aborts it without a done pulse
      do_reset();
      wr(0, 0, 1, 1);
      d = done_cnt[0];
      frame_tick = 1'b1;
      step();                       // e0
      frame_tick = 1'b0;
      step();                       // e1, obj0 moved
      rst = 1'b1;
      step();                       // e2 with reset
      rst = 1'b0;
      check_reset("midrun");
      repeat (8) step();
      check("midrun_no_done", done_cnt[0] - d, 0);

      // host writes on the same edge as the update of that object
      do_reset();
      wr(0, 0, 2, 0);
      wr(0, 1, 3, 3);
      push3(mk(pk(322, 100, 320, 320), pk(240, 100, 240, 240), 4'h0),
            mk(pk(322, 100, 320, 320), pk(240, 100, 240, 240), 4'h0),
            mk(pk(322, 100, 320, 320), pk(240, 100, 240, 240), 4'h0));
      frame_tick = 1'b1;
      step();                       // e0
      frame_tick = 1'b0;
      wr_en = 1'b1; wr_pos = 1'b0; wr_idx = 2'd0; wr_vx = 8'sd10; wr_vy = 8'sd0;
      step();                       // e1: obj0 moves with old v, new v kept
      wr_en = 1'b1; wr_pos = 1'b1; wr_idx = 2'd1; wr_x = 10'd100; wr_y = 10'd100;
      step();                       // e2: written position wins
      wr_en = 1'b0;
      repeat (4) step();
      push3(mk(pk(332, 103, 320, 320), pk(240, 103, 240, 240), 4'h0),
            mk(pk(332, 103, 320, 320), pk(240, 103, 240, 240), 4'h0),
            mk(pk(332, 103, 320, 320), pk(240, 103, 240, 240), 4'h0));
      run_pass(1'b0, 1'b0);

      repeat (4) step();
      check("queues_drained", qa.size() + qb.size() + qc.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected finish before 200000");
      $fatal(1);
   end
endmodule

// File: doc/sprite_motion_array.md
SPRITE_MOTION_ARRAY -- requirements
Module: sprite_motion_array

Interface
REQ-001 SHALL provide parameter NUM_OBJ, default 4, number of tracked objects (2..16); IW = $clog2(NUM_OBJ).
REQ-002 SHALL provide parameter POS_W, default 10, unsigned position width per axis.
REQ-003 SHALL provide parameter VEL_W, default 8, signed velocity width per axis.
REQ-004 SHALL provide parameters X_MIN 0, X_MAX 639, Y_MIN 0, Y_MAX 479, inclusive screen bounds.
REQ-005 SHALL provide parameters X_INIT 320, Y_INIT 240, reset position of every object.
REQ-006 SHALL provide parameter SIZE, default 4, object half-size shared by all objects.
REQ-007 SHALL provide parameter EDGE_MODE, default 0: 0 bounce, 1 wrap, 2 clamp.
REQ-008 SHALL use one clock and a synchronous, active-high reset.
REQ-009 frame_clk  in  1  sole clock, all state on rising edge.
REQ-010 Reset  in  1  synchronous active-high reset.
REQ-011 frame_tick  in  1  single-cycle request to advance all objects one frame.
REQ-012 wr_en  in  1  write strobe; wr_pos  in  1  0 = velocity write, 1 = position write.
REQ-013 wr_idx  in  IW  target object; wr_x, wr_y  in  POS_W  position data; wr_vx, wr_vy  in  VEL_W signed  velocity data.
REQ-014 pos_x, pos_y  out  NUM_OBJ*POS_W  packed positions, object k at bits [k*POS_W +: POS_W].
REQ-015 obj_size  out  POS_W  constant SIZE.
REQ-016 busy  out  1  high while objects are being updated; done  out  1  one-cycle completion pulse.
REQ-017 edge_hit  out  NUM_OBJ  per-object boundary-event flags.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on frame_tick; RUN stays until object NUM_OBJ-1 updated, then ->DONE; DONE->IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 In RUN, one object per edge, index 0 upward; tick sampled at edge e0, object k updated at edge e(k+1), done high for the cycle after e(NUM_OBJ).
REQ-021 frame_tick in RUN or DONE SHALL be ignored.
REQ-022 Per axis: n = p + v computed signed at POS_W+2 bits; v sign-extended.
REQ-023 Bounce: n+SIZE > MAX -> p' = MAX-SIZE, v' = -|v|; n-SIZE < MIN -> p' = MIN+SIZE, v' = +|v|; otherwise p' = n, v unchanged.
REQ-024 Clamp: same position limits as bounce, v' = 0 on the limited axis.
REQ-025 Wrap: n > MAX -> p' = n-(MAX-MIN+1); n < MIN -> p' = n+(MAX-MIN+1); v unchanged.
REQ-026 Negation of -2^(VEL_W-1) SHALL saturate to 2^(VEL_W-1)-1.
REQ-027 Writes SHALL be accepted in any state; written value visible on outputs the edge after wr_en.
REQ-028 Position writes SHALL be stored unchecked; bounds apply at the next update only.
REQ-029 Velocity write to the object being updated on the same edge: position uses the old velocity; the written velocity is stored and any edge-derived v' discarded.
REQ-030 Position write to the object being updated on the same edge: the written position wins.

Reset
REQ-031 On Reset at an edge: all pos = (X_INIT, Y_INIT), all velocities 0, FSM IDLE, busy 0, done 0, edge_hit 0.
REQ-032 Reset mid-RUN SHALL abort the pass with no done pulse; Reset overrides frame_tick and wr_en.

Configuration
REQ-033 Macro SPRITE_EDGE_EVENT_EN defined: edge_hit[k] is set when any boundary action (REQ-023..025) applies to object k, sticky, and cleared for all objects on the edge a frame_tick is accepted.
REQ-034 Macro SPRITE_EDGE_EVENT_EN undefined: edge_hit SHALL be constant 0 with no flag storage.

Verification
REQ-035 Reset asserted one edge -> every pos_x 320, pos_y 240, busy 0, done 0, edge_hit 0.
REQ-036 Write obj1 v=(+5,-3), tick -> obj1 (325,237), others (320,240); busy edges e1..e4; done in the cycle after e4.
REQ-037 Bounce: obj0 pos (630,240), v (+8,0), tick -> x 635, vx -8, edge_hit[0] 1; next tick -> x 627.
REQ-038 Wrap build (EDGE_MODE 1): obj2 x 638, vx +5, tick -> x 3, vx +5; x 1, vx -4 -> x 637.
REQ-039 Clamp build (EDGE_MODE 2): obj3 y 2, vy -6, tick -> y 4, vy 0; tick during RUN ignored, done pulses exactly once.
REQ-040 Reset asserted at e2 of a pass -> reset values at that edge, busy 0, no done; macro undefined build -> edge_hit 0 throughout REQ-037.
